// File: rtl/fixed_point_adder.sv
// Two-stage signed fixed-point adder: operand registers, then a saturating/wrapping result register.
// Latency 2 edges, one pair per cycle, no handshake.
module fixed_point_adder #(
  parameter int WIDTH     = 19,
  parameter int FRAC_BITS = 18,
  parameter int SATURATE  = 1
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic [WIDTH-1:0] Port1,
  input  logic [WIDTH-1:0] Port2,
  output logic [WIDTH-1:0] Output_syn,
  output logic             Overflow
);

  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   s;

  // The binary point position does not affect an aligned add.
  logic unused_frac;
  assign unused_frac = (FRAC_BITS < WIDTH);

  always_comb begin
    s     = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    ovf_d = s[WIDTH] ^ s[WIDTH-1];
    sum_d = s[WIDTH-1:0];
    if ((SATURATE != 0) && ovf_d) begin
      sum_d = s[WIDTH] ? MinNeg : MaxPos;
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= Port1;
      b_q   <= Port2;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
    end
  end

  assign Output_syn = sum_q;
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_fixed_point_adder.sv
// Bench for fixed_point_adder: saturating and wrapping instances against an arithmetic reference.
module tb_fixed_point_adder;
  localparam int W = 19;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] p1, p2;
  logic [W-1:0] out_sat, out_wrap;
  logic         ovf_sat, ovf_wrap;

  always #5 clk = ~clk;

  fixed_point_adder #(.WIDTH(W), .FRAC_BITS(18), .SATURATE(1)) u_dut_sat (
    .clk(clk), .GlobalReset(rst), .Port1(p1), .Port2(p2),
    .Output_syn(out_sat), .Overflow(ovf_sat)
  );

  fixed_point_adder #(.WIDTH(W), .FRAC_BITS(18), .SATURATE(0)) u_dut_wrap (
    .clk(clk), .GlobalReset(rst), .Port1(p1), .Port2(p2),
    .Output_syn(out_wrap), .Overflow(ovf_wrap)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, then clamp or wrap to W bits.
  task automatic ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input bit sat,
                         output logic [W-1:0] r, output bit o);
    int sa, sb, sum;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    sum = sa + sb;
    o   = (sum > (2 ** (W - 1)) - 1) || (sum < -(2 ** (W - 1)));
    if (o && sat) r = (sum > 0) ? W'((2 ** (W - 1)) - 1) : W'(2 ** (W - 1));
    else          r = sum[W-1:0];
  endtask

  // Expected outputs after each edge: the pair sampled one edge earlier, or zero if
  // reset was seen at this edge or the previous one.
  bit           live     = 1'b0;
  bit           prev_rst = 1'b1;
  logic [W-1:0] prev_a   = '0;
  logic [W-1:0] prev_b   = '0;
  logic [W-1:0] exp_sat, exp_wrap;
  bit           exp_osat, exp_owrap;

  always @(posedge clk) begin
    if (rst) begin
      live = 1'b1;
      exp_sat = '0; exp_wrap = '0; exp_osat = 1'b0; exp_owrap = 1'b0;
    end else if (prev_rst) begin
      exp_sat = '0; exp_wrap = '0; exp_osat = 1'b0; exp_owrap = 1'b0;
    end else begin
      ref_add(prev_a, prev_b, 1'b1, exp_sat, exp_osat);
      ref_add(prev_a, prev_b, 1'b0, exp_wrap, exp_owrap);
    end
    prev_rst = rst;
    prev_a   = p1;
    prev_b   = p2;
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model_sat_out",  32'(out_sat),  32'(exp_sat));
      chk("model_sat_ovf",  32'(ovf_sat),  32'(exp_osat));
      chk("model_wrap_out", 32'(out_wrap), 32'(exp_wrap));
      chk("model_wrap_ovf", 32'(ovf_wrap), 32'(exp_owrap));
    end
  end

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return W'(19'h3FFFF);
      1:       return W'(19'h40000);
      2:       return W'(19'h7FFFF);
      3:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [W-1:0] a, b, sat_r, wrap_r;
    bit           ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic stream(input int rst_at, input int n_pairs);
    int sumv;
    for (int i = 0; i < n_pairs + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        sumv = (rst_at >= 0 && (i == rst_at + 1 || i == rst_at + 2)) ? 0 : 4 * (i - 2) + 3;
        chk("stream_out", 32'(out_sat), 32'(sumv));
      end
      rst = (i == rst_at);
      if (i < n_pairs) begin
        p1 = W'(2 * i + 1);
        p2 = W'(2 * i + 2);
      end
    end
  endtask

  initial begin
    logic [W-1:0] r;
    bit           o;

    // Pin the reference model itself.
    ref_add(19'h3FFFF, 19'h3FFFF, 1'b1, r, o); chk("pin_pos_sat", 32'({o, r}), 32'({1'b1, 19'h3FFFF}));
    ref_add(19'h3FFFF, 19'h3FFFF, 1'b0, r, o); chk("pin_pos_wrap", 32'({o, r}), 32'({1'b1, 19'h7FFFE}));
    ref_add(19'h40000, 19'h40000, 1'b1, r, o); chk("pin_neg_sat", 32'({o, r}), 32'({1'b1, 19'h40000}));
    ref_add(19'h40000, 19'h40000, 1'b0, r, o); chk("pin_neg_wrap", 32'({o, r}), 32'({1'b1, 19'h00000}));
    ref_add(19'h22222, 19'h11111, 1'b1, r, o); chk("pin_basic", 32'({o, r}), 32'({1'b0, 19'h33333}));

    vecs[0] = '{19'h22222, 19'h11111, 19'h33333, 19'h33333, 1'b0};
    vecs[1] = '{19'h3FFFF, 19'h40000, 19'h7FFFF, 19'h7FFFF, 1'b0};
    vecs[2] = '{19'h7FFFF, 19'h40000, 19'h40000, 19'h3FFFF, 1'b1};
    vecs[3] = '{19'h3FFFF, 19'h3FFFF, 19'h3FFFF, 19'h7FFFE, 1'b1};
    vecs[4] = '{19'h40000, 19'h40000, 19'h40000, 19'h00000, 1'b1};

    // Reset with random inputs, then release with the basic pair held.
    rst = 1'b1;
    p1  = rnd_val();
    p2  = rnd_val();
    @(negedge clk);
    chk("rst_out", 32'(out_sat), 32'd0);
    chk("rst_ovf", 32'(ovf_sat), 32'd0);
    rst = 1'b0;
    p1  = 19'b0100010001000100010;
    p2  = 19'b0010001000100010001;
    @(negedge clk);
    chk("rel_edge1_out", 32'(out_sat), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("basic_hold_out", 32'(out_sat), 32'(19'b0110011001100110011));
      chk("basic_hold_ovf", 32'(ovf_sat), 32'd0);
    end

    foreach (vecs[k]) begin
      p1 = vecs[k].a;
      p2 = vecs[k].b;
      @(negedge clk);
      @(negedge clk);
      chk("vec_sat_out",  32'(out_sat),  32'(vecs[k].sat_r));
      chk("vec_wrap_out", 32'(out_wrap), 32'(vecs[k].wrap_r));
      chk("vec_ovf",      32'(ovf_sat),  32'(vecs[k].ovf));
      chk("vec_wrap_ovf", 32'(ovf_wrap), 32'(vecs[k].ovf));
      @(negedge clk);
    end

    stream(-1, 4);
    stream(3, 8);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      p1  = rnd_val();
      p2  = rnd_val();
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
